// File: rtl/seven_segment_scan_driver.sv
// Multiplexed hex seven-segment driver: one digit per scan slot, frame-synchronous
// value updates, leading-zero blanking, per-digit decimal points and PWM dimming.
module seven_segment_scan_driver #(
  parameter int clk_mhz    = 50,
  parameter int w_digit    = 8,
  parameter int refresh_hz = 1000,
  parameter int w_bright   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic                   blank_lz,
  input  logic [w_bright-1:0]    brightness,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_done
);

  localparam int period = clk_mhz * 1_000_000 / refresh_hz;
  localparam int w_slot = (period > 1) ? $clog2(period) : 1;
  localparam int w_idx  = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [w_slot-1:0] slot_last = w_slot'(period - 1);
  localparam logic [w_idx-1:0]  idx_last  = w_idx'(w_digit - 1);

  logic [w_slot-1:0]    slot_q, slot_d;
  logic [w_idx-1:0]     idx_q, idx_d;
  logic [w_bright-1:0]  pwm_q, pwm_d;
  logic [4*w_digit-1:0] disp_num_q, disp_num_d, sh_num_q, sh_num_d;
  logic [w_digit-1:0]   disp_dots_q, disp_dots_d, sh_dots_q, sh_dots_d;
  logic                 disp_blz_q, disp_blz_d, sh_blz_q, sh_blz_d;
  logic                 pending_q, pending_d;
  logic [7:0]           abcdefgh_q, abcdefgh_d;
  logic [w_digit-1:0]   digit_q, digit_d;
  logic                 frame_done_q, frame_done_d;

  logic       tick, wrap, pwm_on, zero_above, suppress, dp;
  logic [3:0] nib;

  // Segment order a..g in bits 7:1; bit 0 is the decimal point, filled in later.
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 8'hFC;  4'h1: hex_glyph = 8'h60;
      4'h2: hex_glyph = 8'hDA;  4'h3: hex_glyph = 8'hF2;
      4'h4: hex_glyph = 8'h66;  4'h5: hex_glyph = 8'hB6;
      4'h6: hex_glyph = 8'hBE;  4'h7: hex_glyph = 8'hE0;
      4'h8: hex_glyph = 8'hFE;  4'h9: hex_glyph = 8'hF6;
      4'hA: hex_glyph = 8'hEE;  4'hB: hex_glyph = 8'h3E;
      4'hC: hex_glyph = 8'h9C;  4'hD: hex_glyph = 8'h7A;
      4'hE: hex_glyph = 8'h9E;  default: hex_glyph = 8'h8E;
    endcase
  endfunction

  always_comb begin
    tick   = (slot_q == slot_last);
    wrap   = tick && (idx_q == idx_last);
    slot_d = tick ? '0 : slot_q + 1'b1;
    idx_d  = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    pwm_d  = pwm_q + 1'b1;

    disp_num_d  = disp_num_q;
    disp_dots_d = disp_dots_q;
    disp_blz_d  = disp_blz_q;
    sh_num_d    = sh_num_q;
    sh_dots_d   = sh_dots_q;
    sh_blz_d    = sh_blz_q;
    pending_d   = pending_q;
    // The boundary consumes the shadow as it stood before this cycle's load.
    if (wrap && pending_q) begin
      disp_num_d  = sh_num_q;
      disp_dots_d = sh_dots_q;
      disp_blz_d  = sh_blz_q;
      pending_d   = 1'b0;
    end
    if (load) begin
      sh_num_d  = number;
      sh_dots_d = dots;
      sh_blz_d  = blank_lz;
      pending_d = 1'b1;
    end

    pwm_on     = (pwm_q < brightness) || (&brightness);
    zero_above = 1'b1;
    suppress   = 1'b0;
    nib        = 4'h0;
    dp         = 1'b0;
    digit_d    = '0;
    // Walk from the most significant digit so zero_above covers every higher nibble.
    for (int i = w_digit - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_num_q[4*i +: 4] == 4'h0);
      if (w_idx'(i) == idx_q) begin
        nib        = disp_num_q[4*i +: 4];
        dp         = disp_dots_q[i];
        suppress   = disp_blz_q && (i > 0) && zero_above;
        digit_d[i] = pwm_on;
      end
    end
    abcdefgh_d   = pwm_on ? ((suppress ? 8'h00 : hex_glyph(nib)) | {7'b0, dp}) : 8'h00;
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      disp_num_q   <= '0;
      disp_dots_q  <= '0;
      disp_blz_q   <= 1'b0;
      sh_num_q     <= '0;
      sh_dots_q    <= '0;
      sh_blz_q     <= 1'b0;
      pending_q    <= 1'b0;
      abcdefgh_q   <= 8'h00;
      digit_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      disp_num_q   <= disp_num_d;
      disp_dots_q  <= disp_dots_d;
      disp_blz_q   <= disp_blz_d;
      sh_num_q     <= sh_num_d;
      sh_dots_q    <= sh_dots_d;
      sh_blz_q     <= sh_blz_d;
      pending_q    <= pending_d;
      abcdefgh_q   <= abcdefgh_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign abcdefgh   = abcdefgh_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule
